// File: rtl/iob_axi_lat_ram.sv
// iob_axi_lat_ram
// AXI4 slave front end for an external two-port RAM. The RAM has a registered
// read output, so read data is valid the cycle after r_en.
// The read path waits a fixed latency before it issues the first RAM read.
// The write path can insert periodic one-cycle wready stalls.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   axi_ar* / axi_r*      AXI read address and read data channels
//   axi_aw* / axi_w*      AXI write address and write data channels
//   axi_b*                AXI write response channel
//   ext_mem_r_*           external RAM read port (addr/en out, data in)
//   ext_mem_w_*           external RAM write port (byte strobes, addr, data)
module iob_axi_lat_ram #(
  parameter int ID_W     = 1,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 8,
  parameter int RD_LAT   = 4,
  parameter int WR_STALL = 0,
  localparam int STRB_W  = DATA_W / 8,
  localparam int MEM_AW  = ADDR_W - $clog2(DATA_W / 8)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // AR channel
  input  logic [ADDR_W-1:0] axi_araddr_i,
  input  logic [ID_W-1:0]   axi_arid_i,
  input  logic [LEN_W-1:0]  axi_arlen_i,
  input  logic [1:0]        axi_arburst_i,
  input  logic              axi_arvalid_i,
  output logic              axi_arready_o,
  // R channel
  output logic [DATA_W-1:0] axi_rdata_o,
  output logic [ID_W-1:0]   axi_rid_o,
  output logic [1:0]        axi_rresp_o,
  output logic              axi_rlast_o,
  output logic              axi_rvalid_o,
  input  logic              axi_rready_i,
  // AW channel
  input  logic [ADDR_W-1:0] axi_awaddr_i,
  input  logic [ID_W-1:0]   axi_awid_i,
  input  logic [LEN_W-1:0]  axi_awlen_i,
  input  logic [1:0]        axi_awburst_i,
  input  logic              axi_awvalid_i,
  output logic              axi_awready_o,
  // W channel
  input  logic [DATA_W-1:0] axi_wdata_i,
  input  logic [STRB_W-1:0] axi_wstrb_i,
  input  logic              axi_wlast_i,
  input  logic              axi_wvalid_i,
  output logic              axi_wready_o,
  // B channel
  output logic [ID_W-1:0]   axi_bid_o,
  output logic [1:0]        axi_bresp_o,
  output logic              axi_bvalid_o,
  input  logic              axi_bready_i,
  // external RAM
  output logic              ext_mem_r_en_o,
  output logic [MEM_AW-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i,
  output logic [STRB_W-1:0] ext_mem_w_strb_o,
  output logic [MEM_AW-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o
);

  localparam int BYTE_SH = $clog2(STRB_W);
  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STALL_W = (WR_STALL > 1) ? $clog2(WR_STALL) : 1;

  // ---------------------------------------------------------------- read path
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  r_state_t            r_state_reg, r_state_next;
  logic [MEM_AW-1:0]   r_addr_reg;
  logic [ID_W-1:0]     r_id_reg;
  logic [LEN_W-1:0]    r_len_reg;
  logic [LEN_W-1:0]    r_beat_reg;
  logic                r_fixed_reg;
  logic [LAT_W-1:0]    r_cnt_reg;
  logic [MEM_AW-1:0]   r_addr_step;
  logic                r_last;

  assign r_last      = (r_beat_reg == r_len_reg);
  // word address of the following beat; MEM_AW-bit add wraps naturally
  assign r_addr_step = r_fixed_reg ? r_addr_reg : r_addr_reg + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_id_reg    <= '0;
      r_len_reg   <= '0;
      r_beat_reg  <= '0;
      r_fixed_reg <= 1'b0;
      r_cnt_reg   <= '0;
    end else begin
      r_state_reg <= r_state_next;
      case (r_state_reg)
        R_IDLE: if (axi_arvalid_i) begin
          r_addr_reg  <= MEM_AW'(axi_araddr_i >> BYTE_SH);
          r_id_reg    <= axi_arid_i;
          r_len_reg   <= axi_arlen_i;
          r_fixed_reg <= (axi_arburst_i == 2'b00);
          r_beat_reg  <= '0;
          r_cnt_reg   <= LAT_W'(RD_LAT - 1);
        end
        R_WAIT: if (r_cnt_reg != '0) r_cnt_reg <= r_cnt_reg - 1'b1;
        R_DATA: if (axi_rready_i && !r_last) begin
          r_beat_reg <= r_beat_reg + 1'b1;
          r_addr_reg <= r_addr_step;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (axi_arvalid_i) r_state_next = R_WAIT;
      R_WAIT:  if (r_cnt_reg == '0) r_state_next = R_DATA;
      R_DATA:  if (axi_rready_i && r_last) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi_arready_o    = (r_state_reg == R_IDLE);
    axi_rvalid_o     = (r_state_reg == R_DATA);
    axi_rlast_o      = (r_state_reg == R_DATA) && r_last;
    axi_rdata_o      = ext_mem_r_data_i;
    axi_rid_o        = r_id_reg;
    axi_rresp_o      = 2'b00;
    // the first beat is fetched when the latency expires; each later beat is
    // fetched during the handshake of the previous one, keeping one beat/cycle
    ext_mem_r_en_o   = ((r_state_reg == R_WAIT) && (r_cnt_reg == '0)) ||
                       ((r_state_reg == R_DATA) && axi_rready_i && !r_last);
    ext_mem_r_addr_o = (r_state_reg == R_DATA) ? r_addr_step : r_addr_reg;
  end

  // --------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t            w_state_reg, w_state_next;
  logic [MEM_AW-1:0]   w_addr_reg;
  logic [ID_W-1:0]     w_id_reg;
  logic [LEN_W-1:0]    w_len_reg;
  logic [LEN_W-1:0]    w_beat_reg;
  logic                w_fixed_reg;
  logic [STALL_W-1:0]  w_stall_cnt_reg;
  logic                w_stall_reg;
  logic                w_err_reg;
  logic                w_hs;
  logic                w_final;

  assign w_final = (w_beat_reg == w_len_reg);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_reg     <= W_IDLE;
      w_addr_reg      <= '0;
      w_id_reg        <= '0;
      w_len_reg       <= '0;
      w_beat_reg      <= '0;
      w_fixed_reg     <= 1'b0;
      w_stall_cnt_reg <= '0;
      w_stall_reg     <= 1'b0;
      w_err_reg       <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      case (w_state_reg)
        W_IDLE: if (axi_awvalid_i) begin
          w_addr_reg      <= MEM_AW'(axi_awaddr_i >> BYTE_SH);
          w_id_reg        <= axi_awid_i;
          w_len_reg       <= axi_awlen_i;
          w_fixed_reg     <= (axi_awburst_i == 2'b00);
          w_beat_reg      <= '0;
          w_stall_cnt_reg <= '0;
          w_stall_reg     <= 1'b0;
          w_err_reg       <= 1'b0;
        end
        W_DATA: begin
          if (w_stall_reg) begin
            w_stall_reg <= 1'b0;
          end else if (w_hs) begin
            // wlast must be high exactly on the beat where the count hits len
            w_err_reg <= w_err_reg | (axi_wlast_i != w_final);
            if (!w_final) begin
              w_beat_reg <= w_beat_reg + 1'b1;
              if (!w_fixed_reg) w_addr_reg <= w_addr_reg + 1'b1;
            end
            if (WR_STALL != 0) begin
              if (w_stall_cnt_reg == STALL_W'(WR_STALL - 1)) begin
                w_stall_reg     <= 1'b1;
                w_stall_cnt_reg <= '0;
              end else begin
                w_stall_cnt_reg <= w_stall_cnt_reg + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    case (w_state_reg)
      W_IDLE:  if (axi_awvalid_i) w_state_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_state_next = W_RESP;
      W_RESP:  if (axi_bready_i) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    axi_awready_o    = (w_state_reg == W_IDLE);
    axi_wready_o     = (w_state_reg == W_DATA) && !w_stall_reg;
    w_hs             = axi_wready_o && axi_wvalid_i;
    axi_bvalid_o     = (w_state_reg == W_RESP);
    axi_bid_o        = w_id_reg;
    axi_bresp_o      = w_err_reg ? 2'b10 : 2'b00;
    ext_mem_w_strb_o = w_hs ? axi_wstrb_i : '0;
    ext_mem_w_addr_o = w_addr_reg;
    ext_mem_w_data_o = axi_wdata_i;
  end

endmodule

// File: tb/tb_iob_axi_lat_ram.sv
// Directed plus randomized bench for iob_axi_lat_ram. A reference word array
// is updated from the AXI burst addressing rules as beats are accepted, and
// read bursts are compared against it.
module tb_iob_axi_lat_ram;
  localparam int ID_W     = 4;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int LEN_W    = 8;
  localparam int RD_LAT   = 4;
  localparam int WR_STALL = 2;
  localparam int MEM_AW   = 14;
  localparam int DEPTH    = 1 << MEM_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [ID_W-1:0]   arid, awid, rid, bid;
  logic [LEN_W-1:0]  arlen, awlen;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready;
  logic              bvalid, bready;
  logic [DATA_W-1:0] rdata, wdata;
  logic [3:0]        wstrb;
  logic              r_en;
  logic [MEM_AW-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_data, w_data;
  logic [3:0]        w_strb;

  iob_axi_lat_ram #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .RD_LAT(RD_LAT), .WR_STALL(WR_STALL)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .axi_araddr_i(araddr), .axi_arid_i(arid), .axi_arlen_i(arlen),
    .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rdata_o(rdata), .axi_rid_o(rid), .axi_rresp_o(rresp),
    .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .axi_awaddr_i(awaddr), .axi_awid_i(awid), .axi_awlen_i(awlen),
    .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid),
    .axi_bready_i(bready),
    .ext_mem_r_en_o(r_en), .ext_mem_r_addr_o(r_addr), .ext_mem_r_data_i(r_data),
    .ext_mem_w_strb_o(w_strb), .ext_mem_w_addr_o(w_addr), .ext_mem_w_data_o(w_data)
  );

  // external RAM with registered read output
  logic [DATA_W-1:0] ram [0:DEPTH-1] = '{default: '0};
  always @(posedge clk) begin
    if (r_en) r_data <= ram[r_addr];
    for (int b = 0; b < 4; b++)
      if (w_strb[b]) ram[w_addr][8*b +: 8] <= w_data[8*b +: 8];
  end

  logic [DATA_W-1:0] ref_mem [0:DEPTH-1] = '{default: '0};
  logic [DATA_W-1:0] wd [0:255];
  logic [3:0]        ws [0:255];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // word index of beat i: byte address / 4, held for FIXED, +i otherwise, mod depth
  function automatic int unsigned beat_word(input int unsigned addr, input int unsigned i,
                                            input logic [1:0] burst);
    int unsigned base;
    base = addr >> 2;
    if (burst == 2'b00) return base % DEPTH;
    return (base + i) % DEPTH;
  endfunction

  task automatic do_write(input int unsigned addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input int last_at, input int gap_pct);
    int acc, i, waited;
    bit stall_exp, hs;
    int unsigned w;
    @(negedge clk);
    awaddr = addr[15:0]; awid = id; awlen = len[7:0]; awburst = burst; awvalid = 1'b1;
    #1;
    waited = 0;
    while (!awready && waited < 50) begin @(negedge clk); #1; waited++; end
    check("awready", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    acc = 0; i = 0; stall_exp = 0; waited = 0;
    while (i <= len && waited < 2000) begin
      wvalid = ($urandom_range(99) >= gap_pct);
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at);
      #1;
      check("wready", wready, !stall_exp);
      hs = wvalid && wready;
      w = beat_word(addr, i, burst);
      check("w_strb", w_strb, hs ? ws[i] : 4'h0);
      if (hs) begin
        check("w_addr", w_addr, w);
        check("w_data", w_data, wd[i]);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
        acc++; i++;
        stall_exp = ((acc % WR_STALL) == 0) && (i <= len);
      end else begin
        stall_exp = 0;
      end
      @(negedge clk);
      waited++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_beats", i, len + 1);
    waited = 0;
    while (waited < 200) begin
      bready = 1'($urandom_range(1));
      #1;
      if (bvalid && bready) break;
      @(negedge clk);
      waited++;
    end
    check("bvalid", bvalid, 1);
    check("bid", bid, id);
    check("bresp", bresp, (last_at == len) ? 2'b00 : 2'b10);
    $display("write addr=%h len=%0d burst=%0d bresp=%0d", addr, len, burst, bresp);
    @(negedge clk);
    bready = 1'b0;
    #1;
    check("bvalid_clear", bvalid, 0);
    check("awready_back", awready, 1);
  endtask

  // mode: 0 rready always 1, 1 toggling, 2 random; abort_at >= 0 resets at that beat
  task automatic do_read(input int unsigned addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input int mode, input int abort_at);
    int waited, i, lat;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    araddr = addr[15:0]; arid = id; arlen = len[7:0]; arburst = burst; arvalid = 1'b1;
    #1;
    waited = 0;
    while (!arready && waited < 50) begin @(negedge clk); #1; waited++; end
    check("arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    lat = 1;
    while (!rvalid && lat < RD_LAT + 20) begin @(negedge clk); #1; lat++; end
    check("r_latency", lat, RD_LAT + 1);
    i = 0; waited = 0;
    while (i <= len && waited < 1000) begin
      if (i == abort_at) begin
        rready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_arready", arready, 1);
        check("rst_r_en", r_en, 0);
        check("rst_bvalid", bvalid, 0);
        $display("read addr=%h aborted by reset at beat %0d", addr, i);
        return;
      end
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((waited % 2) == 0) : 1'($urandom_range(1));
      #1;
      exp_d = ref_mem[beat_word(addr, i, burst)];
      check("rvalid", rvalid, 1);
      check("rdata", rdata, exp_d);
      check("rid", rid, id);
      check("rresp", rresp, 0);
      check("rlast", rlast, i == len);
      check("r_en", r_en, rready && (i < len));
      if (rready && rvalid) i++;
      @(negedge clk);
      waited++;
    end
    rready = 1'b0;
    #1;
    check("r_beats", i, len + 1);
    check("rvalid_end", rvalid, 0);
    check("arready_end", arready, 1);
    $display("read addr=%h len=%0d burst=%0d mode=%0d beats=%0d", addr, len, burst, mode, i);
  endtask

  initial begin
    rst = 1'b1;
    araddr = '0; arid = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_arready", arready, 1);
    check("reset_awready", awready, 1);
    check("reset_rvalid", rvalid, 0);
    check("reset_wready", wready, 0);
    check("reset_bvalid", bvalid, 0);
    check("reset_r_en", r_en, 0);
    check("reset_w_strb", w_strb, 0);
    rst = 1'b0;

    // 4-beat INCR write of 0xA0..0xA3, then read back at full rate
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0 + k; ws[k] = 4'hF; end
    do_write(32'h100, 4'h1, 3, 2'b01, 3, 0);
    do_read(32'h100, 4'h2, 3, 2'b01, 0, -1);

    // 6-beat write exercising periodic stalls, read back with toggling rready
    for (int k = 0; k < 6; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(32'h200, 4'h3, 5, 2'b01, 5, 0);
    do_read(32'h200, 4'h4, 5, 2'b01, 1, -1);

    // early wlast: all beats still written, SLVERR
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(32'h300, 4'h5, 3, 2'b01, 1, 0);
    do_read(32'h300, 4'h6, 3, 2'b01, 0, -1);
    // wlast never asserted: SLVERR
    for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(32'h340, 4'h7, 2, 2'b01, -1, 0);

    // FIXED burst merging three byte lanes into one word
    wd[0] = 32'h11223344; ws[0] = 4'b0001;
    wd[1] = 32'h55667788; ws[1] = 4'b0010;
    wd[2] = 32'h99AABBCC; ws[2] = 4'b0100;
    do_write(32'h40, 4'h8, 2, 2'b00, 2, 0);
    do_read(32'h40, 4'h9, 0, 2'b01, 0, -1);
    do_read(32'h40, 4'hA, 2, 2'b00, 2, -1);

    // INCR burst wrapping past the top of the word space
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(32'hFFF8, 4'hB, 3, 2'b01, 3, 0);
    do_read(32'hFFF8, 4'hC, 3, 2'b01, 2, -1);

    // reset in the middle of a read burst, then a fresh burst
    do_read(32'h100, 4'hD, 3, 2'b01, 0, 2);
    do_read(32'h100, 4'hE, 3, 2'b01, 0, -1);

    // randomized bursts
    for (int t = 0; t < 20; t++) begin
      int unsigned a;
      int l;
      logic [1:0] bt;
      a = $urandom_range(0, 16'hFFFF);
      l = $urandom_range(0, 7);
      bt = 2'($urandom_range(0, 3));
      for (int k = 0; k <= l; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      do_write(a, 4'($urandom), l, bt, l, 30);
      do_read(a, 4'($urandom), l, bt, 2, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/iob_axi_lat_ram.md
IOB_AXI_LAT_RAM -- requirements
Module: iob_axi_lat_ram

Interface
REQ-001 Parameter ID_W, default 1: AXI ID width.
REQ-002 Parameter ADDR_W, default 16: AXI byte-address width.
REQ-003 Parameter DATA_W, default 32: AXI/memory data width, power of two, at least 8.
REQ-004 Parameter LEN_W, default 8: AXI burst-length width.
REQ-005 Parameter RD_LAT, default 4, minimum 1: cycles from AR handshake to first ext_mem_r_en_o.
REQ-006 Parameter WR_STALL, default 0: wready deasserted one cycle after every WR_STALL accepted W beats; 0 disables stalls.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 Ports clk_i and rst_i, each input, 1 bit: clock, and synchronous active-high reset.
REQ-009 AR channel ports:
- axi_araddr_i, input, ADDR_W.
- axi_arid_i, input, ID_W.
- axi_arlen_i, input, LEN_W.
- axi_arburst_i, input, 2.
- axi_arvalid_i, input, 1.
- axi_arready_o, output, 1.
REQ-010 R channel ports:
- axi_rdata_o, output, DATA_W.
- axi_rid_o, output, ID_W.
- axi_rresp_o, output, 2.
- axi_rlast_o, output, 1.
- axi_rvalid_o, output, 1.
- axi_rready_i, input, 1.
REQ-011 AW channel ports:
- axi_awaddr_i, input, ADDR_W.
- axi_awid_i, input, ID_W.
- axi_awlen_i, input, LEN_W.
- axi_awburst_i, input, 2.
- axi_awvalid_i, input, 1.
- axi_awready_o, output, 1.
REQ-012 W channel ports:
- axi_wdata_i, input, DATA_W.
- axi_wstrb_i, input, DATA_W/8.
- axi_wlast_i, input, 1.
- axi_wvalid_i, input, 1.
- axi_wready_o, output, 1.
REQ-013 B channel ports:
- axi_bid_o, output, ID_W.
- axi_bresp_o, output, 2.
- axi_bvalid_o, output, 1.
- axi_bready_i, input, 1.
REQ-014 External memory ports (registered-output two-port RAM, read data valid the cycle after r_en):
- ext_mem_r_en_o, output, 1.
- ext_mem_r_addr_o, output, MEM_AW.
- ext_mem_r_data_i, input, DATA_W.
- ext_mem_w_strb_o, output, DATA_W/8.
- ext_mem_w_addr_o, output, MEM_AW.
- ext_mem_w_data_o, output, DATA_W.
- MEM_AW = ADDR_W - log2(DATA_W/8).

Function
REQ-015 Word address SHALL be byte address >> log2(DATA_W/8). Burst FIXED (00) SHALL hold the address; any other burst value SHALL increment the word address by 1 per beat, wrapping modulo 2^MEM_AW.
REQ-016 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; arready_o=1 only in R_IDLE.
REQ-017 AR handshake SHALL latch address, id and len into registers, load the latency counter with RD_LAT-1, and enter R_WAIT.
REQ-018 R_WAIT SHALL decrement the counter each cycle; at 0 it SHALL pulse r_en for beat 0 and enter R_DATA, with rvalid_o=1 from the next cycle.
REQ-019 In R_DATA, rdata_o SHALL equal ext_mem_r_data_i; rid_o SHALL equal the latched id; rresp_o SHALL be 00; rlast_o=1 on beat len.
REQ-020 A non-last R handshake SHALL pulse r_en for the next beat in the same cycle, so rvalid stays high and throughput is one beat per cycle.
REQ-021 The last R handshake SHALL return the read FSM to R_IDLE. With rready_i low, rvalid/rdata/rlast SHALL be held and no r_en issued.
REQ-022 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready_o=1 only in W_IDLE. AW handshake SHALL latch address, id and len, clear the beat and stall counters, and enter W_DATA.
REQ-023 In W_DATA, wready_o SHALL be 1 except during a stall cycle. Each W handshake SHALL drive ext_mem_w_strb_o=wstrb, w_addr and w_data for that cycle; otherwise ext_mem_w_strb_o SHALL be 0.
REQ-024 The burst SHALL terminate on the beat counter reaching len, not on wlast.
REQ-025 bresp SHALL be 10 (SLVERR) if wlast_i mismatched on any beat (asserted early, or absent on the final beat); otherwise 00.
REQ-026 W_RESP SHALL assert bvalid_o with the latched bid until bready_i, then return to W_IDLE.
REQ-027 Read and write FSMs SHALL operate concurrently and independently. Read data for an address written in the same cycle is undefined; no ordering between the channels is guaranteed.

Reset
REQ-028 rst_i SHALL, at the next clock edge, force both FSMs idle and clear all counters and latched fields.
REQ-029 Output reset values: arready_o=awready_o=1, rvalid_o=wready_o=bvalid_o=0, ext_mem_r_en_o=0, ext_mem_w_strb_o=0.
REQ-030 Reset mid-burst SHALL abandon the burst with no R or B response.

Verification
REQ-031 Write 4 beats INCR at 0x100 (data 0xA0..0xA3, WR_STALL=0), then read len=3 at 0x100 -> B OKAY; first rvalid exactly RD_LAT+1 cycles after the AR handshake; data 0xA0..0xA3 on 4 consecutive cycles; rlast on beat 3.
REQ-032 WR_STALL=2, 6-beat write -> wready low for exactly one cycle after beats 2 and 4; all 6 words stored.
REQ-033 Read with rready_i toggling 1/0 -> each beat held stable while rready_i=0; no duplicated or skipped words.
REQ-034 AW len=3 with wlast_i on beat 1 -> 4 beats written, bresp=10.
REQ-035 FIXED write of 3 beats (wstrb 0001, 0010, 0100) at 0x40 -> a single word merging all three bytes.
REQ-036 rst_i asserted in R_DATA mid-burst, then a new AR -> rvalid=0 the cycle after reset; the new burst completes correctly.
